onchip_mem_s2_arbiter: RTL and testbench



---
 rtl/onchip_mem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 36 +++
 rtl/onchip_mem_s2_arbiter.sv | 166 ++++++++++++++++
 tb/tb_onchip_mem_s2_arbiter.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// Shared defaults and types for the on-chip memory s2 port arbiter.
package onchip_mem_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 64;
  localparam int RD_LAT_DEF = 1;

  typedef logic req_id_t;

  // Travels alongside each access so read data can be steered to its issuer.
  typedef struct packed {
    logic    is_read;
    req_id_t id;
  } arb_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on conflict, the requester not granted most recently wins.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  req_id_t last_grant_q;
  req_id_t last_grant_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // The pointer moves only when the grant is actually consumed.
  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i) last_grant_d = grant_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_grant_q <= 1'b1;
    else         last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/onchip_mem_s2_arbiter.sv
// Shares on-chip memory port s2 between two requesters with registered strobes and tagged read return.
// Optional transfer/conflict counters are built when ONCHIP_MEM_ARB_STATS_EN is defined.
module onchip_mem_s2_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [DATA_W-1:0] req0_writedata,
  input  logic [BE_W-1:0]   req0_byteenable,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_readdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [DATA_W-1:0] req1_writedata,
  input  logic [BE_W-1:0]   req1_byteenable,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_readdata,
  output logic [ADDR_W-1:0] on_chip_mem_s2_address,
  output logic              on_chip_mem_s2_chipselect,
  output logic              on_chip_mem_s2_clken,
  output logic              on_chip_mem_s2_write,
  output logic [DATA_W-1:0] on_chip_mem_s2_writedata,
  output logic [BE_W-1:0]   on_chip_mem_s2_byteenable,
  input  logic [DATA_W-1:0] on_chip_mem_s2_readdata
`ifdef ONCHIP_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_grant0,
  output logic [31:0]       stat_grant1,
  output logic [31:0]       stat_conflict
`endif
);

  // Handshake: a request moves when valid and ready are both 1; ready is
  // combinational from valid and the round-robin pointer, never both high.
  logic [1:0]        valid;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              xfer;
  req_id_t           sel;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;

  assign valid = {req1_valid, req0_valid};

  rr_arb2 u_rr (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .valid_i   (valid),
    .advance_i (xfer),
    .grant_o   (grant)
  );

  assign ready      = grant & {2{reset_reset_n}};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign xfer       = |ready;
  assign sel        = ready[1];

  assign sel_write = sel ? req1_write      : req0_write;
  assign sel_addr  = sel ? req1_address    : req0_address;
  assign sel_wdata = sel ? req1_writedata  : req0_writedata;
  assign sel_be    = sel ? req1_byteenable : req0_byteenable;

  logic              cs_q, cs_d;
  logic              wr_q, wr_d;
  logic              clken_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;

  always_comb begin
    cs_d    = xfer;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (xfer) begin
      wr_d    = sel_write;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      be_d    = sel_write ? sel_be : '1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      clken_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      clken_q <= 1'b1;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign on_chip_mem_s2_address    = addr_q;
  assign on_chip_mem_s2_chipselect = cs_q;
  assign on_chip_mem_s2_clken      = clken_q;
  assign on_chip_mem_s2_write      = wr_q;
  assign on_chip_mem_s2_writedata  = wdata_q;
  assign on_chip_mem_s2_byteenable = be_q;

  // Stage 0 lines up with the strobe cycle; stage RD_LAT with the returned data.
  arb_tag_t tag_q [RD_LAT+1];
  arb_tag_t tag_d;

  always_comb begin
    tag_d.is_read = xfer & ~sel_write;
    tag_d.id      = sel;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign req0_rvalid   = tag_q[RD_LAT].is_read & ~tag_q[RD_LAT].id;
  assign req1_rvalid   = tag_q[RD_LAT].is_read &  tag_q[RD_LAT].id;
  assign req0_readdata = on_chip_mem_s2_readdata;
  assign req1_readdata = on_chip_mem_s2_readdata;

`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic [31:0] grant0_q, grant1_q, conflict_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (ready[0] && grant0_q != '1)     grant0_q   <= grant0_q + 32'd1;
      if (ready[1] && grant1_q != '1)     grant1_q   <= grant1_q + 32'd1;
      if ((&valid) && conflict_q != '1)   conflict_q <= conflict_q + 32'd1;
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_onchip_mem_s2_arbiter.sv
// Self-checking bench for onchip_mem_s2_arbiter: default-latency instance plus an RD_LAT=3 instance.
module tb_onchip_mem_s2_arbiter;

  localparam int RD_LAT  = 1;
  localparam int RD_LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk = 0;
  int err = 0;

  logic        rq_valid [2];
  logic        rq_write [2];
  logic [13:0] rq_addr  [2];
  logic [63:0] rq_wdata [2];
  logic [7:0]  rq_be    [2];
  logic        rq_ready [2];
  logic        rq_rvalid[2];
  logic [63:0] rq_rdata [2];
  logic [13:0] s2_addr;
  logic        s2_cs, s2_clken, s2_write;
  logic [63:0] s2_wdata, s2_rdata;
  logic [7:0]  s2_be;

  logic        t_valid [2];
  logic        t_addr_dummy_write [2];
  logic [13:0] t_addr  [2];
  logic        t_ready [2];
  logic        t_rvalid[2];
  logic [63:0] t_rdata [2];
  logic [13:0] s3_addr;
  logic        s3_cs, s3_clken, s3_write;
  logic [63:0] s3_wdata, s3_rdata;
  logic [7:0]  s3_be;
  logic [63:0] zero64 = 64'h0;
  logic [7:0]  zero8 = 8'h0;

`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic [31:0] st_g0, st_g1, st_cf, st3_g0, st3_g1, st3_cf;
`endif

  onchip_mem_s2_arbiter #(.ADDR_W(14), .DATA_W(64), .RD_LAT(RD_LAT)) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req0_valid(rq_valid[0]), .req0_ready(rq_ready[0]), .req0_write(rq_write[0]),
    .req0_address(rq_addr[0]), .req0_writedata(rq_wdata[0]), .req0_byteenable(rq_be[0]),
    .req0_rvalid(rq_rvalid[0]), .req0_readdata(rq_rdata[0]),
    .req1_valid(rq_valid[1]), .req1_ready(rq_ready[1]), .req1_write(rq_write[1]),
    .req1_address(rq_addr[1]), .req1_writedata(rq_wdata[1]), .req1_byteenable(rq_be[1]),
    .req1_rvalid(rq_rvalid[1]), .req1_readdata(rq_rdata[1]),
    .on_chip_mem_s2_address(s2_addr), .on_chip_mem_s2_chipselect(s2_cs),
    .on_chip_mem_s2_clken(s2_clken), .on_chip_mem_s2_write(s2_write),
    .on_chip_mem_s2_writedata(s2_wdata), .on_chip_mem_s2_byteenable(s2_be),
    .on_chip_mem_s2_readdata(s2_rdata)
`ifdef ONCHIP_MEM_ARB_STATS_EN
    , .stat_grant0(st_g0), .stat_grant1(st_g1), .stat_conflict(st_cf)
`endif
  );

  onchip_mem_s2_arbiter #(.ADDR_W(14), .DATA_W(64), .RD_LAT(RD_LAT3)) u_dut3 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .req0_valid(t_valid[0]), .req0_ready(t_ready[0]), .req0_write(t_addr_dummy_write[0]),
    .req0_address(t_addr[0]), .req0_writedata(zero64), .req0_byteenable(zero8),
    .req0_rvalid(t_rvalid[0]), .req0_readdata(t_rdata[0]),
    .req1_valid(t_valid[1]), .req1_ready(t_ready[1]), .req1_write(t_addr_dummy_write[1]),
    .req1_address(t_addr[1]), .req1_writedata(zero64), .req1_byteenable(zero8),
    .req1_rvalid(t_rvalid[1]), .req1_readdata(t_rdata[1]),
    .on_chip_mem_s2_address(s3_addr), .on_chip_mem_s2_chipselect(s3_cs),
    .on_chip_mem_s2_clken(s3_clken), .on_chip_mem_s2_write(s3_write),
    .on_chip_mem_s2_writedata(s3_wdata), .on_chip_mem_s2_byteenable(s3_be),
    .on_chip_mem_s2_readdata(s3_rdata)
`ifdef ONCHIP_MEM_ARB_STATS_EN
    , .stat_grant0(st3_g0), .stat_grant1(st3_g1), .stat_conflict(st3_cf)
`endif
  );

  // Memory model for the default instance: write applied at the strobe edge, read data one cycle later.
  logic [63:0] ram [0:16383];
  logic [63:0] ram_rd_q;
  always @(posedge clk) begin
    if (s2_cs && s2_clken) begin
      if (s2_write) begin
        for (int b = 0; b < 8; b++)
          if (s2_be[b]) ram[s2_addr][8*b +: 8] <= s2_wdata[8*b +: 8];
      end else begin
        ram_rd_q <= ram[s2_addr];
      end
    end
  end
  assign s2_rdata = ram_rd_q;

  function automatic logic [63:0] pat(input logic [13:0] a);
    return {18'h0, a, 18'h3FFFF, ~a};
  endfunction

  // Read-only pattern memory with three cycles of latency for the RD_LAT=3 instance.
  logic [63:0] rd3_p [3];
  always @(posedge clk) begin
    rd3_p[0] <= pat(s3_addr);
    rd3_p[1] <= rd3_p[0];
    rd3_p[2] <= rd3_p[1];
  end
  assign s3_rdata = rd3_p[2];

  // Scoreboard state
  logic [63:0] ref_mem [0:16383];
  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [64:0] exp3_q[$];
  int          exp3_cyc_q[$];
  logic        grant_log[$];
  int          xfer_cyc[$];
  logic        rv3_ids[$];
  logic [63:0] last_rdata;
  logic        last_id;
  logic        prev_xfer = 1'b0;
  logic        prev_wr;
  logic [13:0] prev_addr;
  logic [63:0] prev_wdata;
  logic [7:0]  prev_be;

  always @(negedge clk) begin
    logic        cur_x;
    logic        cur_wr;
    logic [13:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [7:0]  cur_be;
    logic        id;
    logic [64:0] e;
    int          ec;
    cur_x = 1'b0; cur_wr = 1'b0; cur_addr = '0; cur_wdata = '0; cur_be = '0;
    chk++;
    if (rq_ready[0] && rq_ready[1]) begin
      err++; $display("FAIL one_ready cyc=%0d got both ready want at most one", cyc);
    end
    for (int n = 0; n < 2; n++) begin
      if (rq_valid[n] && rq_ready[n]) begin
        grant_log.push_back(n[0]);
        xfer_cyc.push_back(cyc);
        cur_x = 1'b1; cur_wr = rq_write[n]; cur_addr = rq_addr[n];
        cur_wdata = rq_wdata[n]; cur_be = rq_write[n] ? rq_be[n] : 8'hFF;
        if (rq_write[n]) begin
          for (int b = 0; b < 8; b++)
            if (rq_be[n][b]) ref_mem[rq_addr[n]][8*b +: 8] = rq_wdata[n][8*b +: 8];
        end else begin
          exp_q.push_back({n[0], ref_mem[rq_addr[n]]});
          exp_cyc_q.push_back(cyc + 1 + RD_LAT);
        end
      end
    end
    chk++;
    if (s2_cs !== prev_xfer) begin
      err++; $display("FAIL s2_chipselect cyc=%0d got %b want %b", cyc, s2_cs, prev_xfer);
    end
    if (prev_xfer) begin
      chk++;
      if (s2_addr !== prev_addr || s2_write !== prev_wr || s2_be !== prev_be ||
          (prev_wr && s2_wdata !== prev_wdata)) begin
        err++;
        $display("FAIL s2_strobe cyc=%0d got a=%h w=%b be=%h d=%h want a=%h w=%b be=%h d=%h",
                 cyc, s2_addr, s2_write, s2_be, s2_wdata, prev_addr, prev_wr, prev_be, prev_wdata);
      end
    end
    prev_xfer = cur_x; prev_wr = cur_wr; prev_addr = cur_addr;
    prev_wdata = cur_wdata; prev_be = cur_be;
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      chk++; err++;
      $display("FAIL rvalid_missing cyc=%0d got none want rvalid at cyc %0d", cyc, exp_cyc_q[0]);
      void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front());
    end
    if (rq_rvalid[0] || rq_rvalid[1]) begin
      chk++;
      id = rq_rvalid[1];
      if (rq_rvalid[0] && rq_rvalid[1]) begin
        err++; $display("FAIL rvalid_onehot cyc=%0d got both want one", cyc);
      end else if (exp_q.size() == 0) begin
        err++; $display("FAIL rvalid_unexpected cyc=%0d got id=%0d want none", cyc, id);
      end else begin
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        last_id = id;
        last_rdata = id ? rq_rdata[1] : rq_rdata[0];
        if ({id, last_rdata} !== e || cyc != ec) begin
          err++;
          $display("FAIL read_return cyc=%0d got id=%0d d=%h want id=%0d d=%h cyc=%0d",
                   cyc, id, last_rdata, e[64], e[63:0], ec);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        id;
    logic [64:0] e;
    int          ec;
    for (int n = 0; n < 2; n++) begin
      if (t_valid[n] && t_ready[n]) begin
        exp3_q.push_back({n[0], pat(t_addr[n])});
        exp3_cyc_q.push_back(cyc + 1 + RD_LAT3);
      end
    end
    if (exp3_cyc_q.size() > 0 && exp3_cyc_q[0] < cyc) begin
      chk++; err++;
      $display("FAIL rvalid3_missing cyc=%0d got none want rvalid at cyc %0d", cyc, exp3_cyc_q[0]);
      void'(exp3_q.pop_front()); void'(exp3_cyc_q.pop_front());
    end
    if (t_rvalid[0] || t_rvalid[1]) begin
      chk++;
      id = t_rvalid[1];
      if (t_rvalid[0] && t_rvalid[1]) begin
        err++; $display("FAIL rvalid3_onehot cyc=%0d got both want one", cyc);
      end else if (exp3_q.size() == 0) begin
        err++; $display("FAIL rvalid3_unexpected cyc=%0d got id=%0d want none", cyc, id);
      end else begin
        e = exp3_q.pop_front(); ec = exp3_cyc_q.pop_front();
        rv3_ids.push_back(id);
        if ({id, (id ? t_rdata[1] : t_rdata[0])} !== e || cyc != ec) begin
          err++;
          $display("FAIL read3_return cyc=%0d got id=%0d want id=%0d d=%h cyc=%0d",
                   cyc, id, e[64], e[63:0], ec);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive_req(input int id, input logic wr, input logic [13:0] a,
                           input logic [63:0] d, input logic [7:0] be);
    logic got;
    got = 1'b0;
    rq_write[id] = wr; rq_addr[id] = a; rq_wdata[id] = d; rq_be[id] = be;
    rq_valid[id] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = rq_ready[id];
    end
    chk++;
    if (!got) begin
      err++; $display("FAIL req_timeout id=%0d got ready=0 want 1", id);
    end
    @(posedge clk); #1;
    rq_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && (exp_q.size() > 0 || exp3_q.size() > 0); k++) @(negedge clk);
    chk++;
    if (exp_q.size() > 0 || exp3_q.size() > 0) begin
      err++; $display("FAIL drain got %0d/%0d pending want 0", exp_q.size(), exp3_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic flush_sb();
    exp_q.delete(); exp_cyc_q.delete(); exp3_q.delete(); exp3_cyc_q.delete();
    grant_log.delete(); xfer_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin rq_valid[n] = 1'b0; t_valid[n] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    flush_sb();
    rst_n = 1'b1;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk++;
    if (rq_ready[0] !== 1'b0 || rq_ready[1] !== 1'b0) begin
      err++; $display("FAIL reset_ready got %b%b want 00", rq_ready[1], rq_ready[0]);
    end
    chk++;
    if ({s2_cs, s2_write, s2_clken} !== 3'b000 || s2_addr !== 14'h0 ||
        s2_wdata !== 64'h0 || s2_be !== 8'h0) begin
      err++; $display("FAIL reset_s2 got cs=%b w=%b ck=%b a=%h d=%h be=%h want all 0",
                      s2_cs, s2_write, s2_clken, s2_addr, s2_wdata, s2_be);
    end
    chk++;
    if (rq_rvalid[0] !== 1'b0 || rq_rvalid[1] !== 1'b0) begin
      err++; $display("FAIL reset_rvalid got %b%b want 00", rq_rvalid[1], rq_rvalid[0]);
    end
    @(posedge clk); #1;
    rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
    flush_sb();
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk++;
    if (s2_clken !== 1'b1) begin
      err++; $display("FAIL clken_after_reset got %b want 1", s2_clken);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    drive_req(0, 1'b1, 14'h0010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    drive_req(1, 1'b0, 14'h0010, 64'h0, 8'h0);
    wait_idle();
    chk++;
    if (last_rdata !== 64'hDEAD_BEEF_0123_4567 || last_id !== 1'b1) begin
      err++; $display("FAIL write_read got id=%0d d=%h want id=1 d=deadbeef01234567", last_id, last_rdata);
    end
  endtask

  task automatic test_byteenable();
    drive_req(0, 1'b1, 14'h0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    drive_req(0, 1'b1, 14'h0020, 64'h0, 8'h0F);
    drive_req(1, 1'b0, 14'h0020, 64'h0, 8'h0);
    wait_idle();
    chk++;
    if (last_rdata !== 64'hFFFF_FFFF_0000_0000) begin
      err++; $display("FAIL be_partial got %h want ffffffff00000000", last_rdata);
    end
    drive_req(1, 1'b1, 14'h0020, 64'h0, 8'h00);
    drive_req(0, 1'b0, 14'h0020, 64'h0, 8'h0);
    wait_idle();
    chk++;
    if (last_rdata !== 64'hFFFF_FFFF_0000_0000 || last_id !== 1'b0) begin
      err++; $display("FAIL be_zero got id=%0d d=%h want id=0 d=ffffffff00000000", last_id, last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    grant_log.delete(); xfer_cyc.delete();
    fork
      drive_req(0, 1'b1, 14'h0030, 64'h1122_3344_5566_7788, 8'hFF);
      begin
        @(posedge clk); #1;
        drive_req(1, 1'b0, 14'h0030, 64'h0, 8'h0);
      end
    join
    wait_idle();
    chk++;
    if (xfer_cyc.size() != 2 || xfer_cyc[1] != xfer_cyc[0] + 1) begin
      err++; $display("FAIL b2b_timing got %0d transfers want 2 in consecutive cycles", xfer_cyc.size());
    end
    chk++;
    if (last_rdata !== 64'h1122_3344_5566_7788) begin
      err++; $display("FAIL raw got %h want 1122334455667788", last_rdata);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    rq_write[0] = 1'b0; rq_addr[0] = 14'h0010;
    rq_write[1] = 1'b0; rq_addr[1] = 14'h0030;
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
    chk++;
    if (grant_log.size() != 8) begin
      err++; $display("FAIL conflict_count got %0d want 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        chk++;
        if (grant_log[i] !== i[0]) begin
          err++; $display("FAIL conflict_grant[%0d] got %0d want %0d", i, grant_log[i], i[0]);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      drive_req(0, 1'b1, 14'h0040 + 14'(i), {$urandom, $urandom}, 8'hFF);
    fork
      for (int i = 0; i < 30; i++) begin
        drive_req(0, 1'($urandom_range(0, 1)), 14'h0040 + 14'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 30; i++) begin
        drive_req(1, 1'($urandom_range(0, 1)), 14'h0040 + 14'($urandom_range(0, 15)),
                  {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
    join
    wait_idle();
  endtask

  task automatic test_reset_mid();
    drive_req(0, 1'b0, 14'h0010, 64'h0, 8'h0);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk++;
    if ({s2_cs, s2_write, s2_clken} !== 3'b000 || s2_addr !== 14'h0 ||
        s2_wdata !== 64'h0 || s2_be !== 8'h0 ||
        rq_rvalid[0] !== 1'b0 || rq_rvalid[1] !== 1'b0) begin
      err++; $display("FAIL mid_reset_outputs got cs=%b w=%b ck=%b a=%h be=%h rv=%b%b want all 0",
                      s2_cs, s2_write, s2_clken, s2_addr, s2_be, rq_rvalid[1], rq_rvalid[0]);
    end
    @(posedge clk); #1;
    flush_sb();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk++;
      if (rq_rvalid[0] !== 1'b0 || rq_rvalid[1] !== 1'b0) begin
        err++; $display("FAIL dropped_read k=%0d got rvalid=%b%b want 00", k, rq_rvalid[1], rq_rvalid[0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rdlat3();
    rv3_ids.delete();
    t_addr[0] = 14'h0100; t_addr[1] = 14'h02A5;
    t_valid[0] = 1'b1; t_valid[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    t_valid[0] = 1'b0; t_valid[1] = 1'b0;
    wait_idle();
    chk++;
    if (rv3_ids.size() != 6) begin
      err++; $display("FAIL rdlat3_count got %0d want 6", rv3_ids.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        chk++;
        if (rv3_ids[i] === rv3_ids[i-1]) begin
          err++; $display("FAIL rdlat3_alternate[%0d] got %0d want %0d", i, rv3_ids[i], !rv3_ids[i-1]);
        end
      end
    end
  endtask

  task automatic test_stats();
`ifdef ONCHIP_MEM_ARB_STATS_EN
    do_reset();
    rq_write[0] = 1'b0; rq_addr[0] = 14'h0010;
    rq_write[1] = 1'b0; rq_addr[1] = 14'h0030;
    rq_valid[0] = 1'b1; rq_valid[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rq_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rq_valid[1] = 1'b0;
    @(negedge clk);
    chk++;
    if (st_cf !== 32'd5 || st_g0 !== 32'd3 || st_g1 !== 32'd5) begin
      err++; $display("FAIL stats got cf=%0d g0=%0d g1=%0d want cf=5 g0=3 g1=5", st_cf, st_g0, st_g1);
    end
    wait_idle();
`endif
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      rq_valid[n] = 1'b0; rq_write[n] = 1'b0; rq_addr[n] = '0; rq_wdata[n] = '0; rq_be[n] = '0;
      t_valid[n] = 1'b0; t_addr[n] = '0; t_addr_dummy_write[n] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_byteenable();
    test_back_to_back();
    test_conflict();
    test_random();
    test_reset_mid();
    test_rdlat3();
    test_stats();
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
